// File: rtl/avalon_mm_slave_regs_if.sv
// Avalon-MM bus bundle between the UART-side master and the register-window slave.
// Signal names follow the Avalon naming used on the rest of the bridge.
interface avalon_mm_slave_regs_if;
  logic [31:0] ADDRESS;
  logic        BEGINTRANSFER;
  logic        READ;
  logic        WRITE;
  logic [31:0] WRITEDATA;
  logic        LOCK;
  logic [31:0] READDATA;
  logic        WAITREQUEST;

  modport master (
    output ADDRESS, BEGINTRANSFER, READ, WRITE, WRITEDATA, LOCK,
    input  READDATA, WAITREQUEST
  );

  modport slave (
    input  ADDRESS, BEGINTRANSFER, READ, WRITE, WRITEDATA, LOCK,
    output READDATA, WAITREQUEST
  );
endinterface

// File: rtl/avalon_mm_slave_regs.sv
// Avalon-MM register window for the UART bridge: four RW words, one RO transmit word,
// a fixed WAITREQUEST stall per transfer, write-notify pulses and a sticky error flag.
module avalon_mm_slave_regs #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] RD_DEFAULT  = 32'h0000_0000
) (
  input  logic                   CLK,
  input  logic                   RST,
  avalon_mm_slave_regs_if.slave  bus,
  output logic [31:0]            reg0_o,
  output logic [31:0]            reg1_o,
  output logic [31:0]            reg2_o,
  output logic [31:0]            reg4_o,
  output logic [4:0]             wr_pulse_o,
  input  logic [31:0]            tx_word_i,
  input  logic                   tx_valid_i,
  output logic                   tx_taken_o,
  output logic                   lock_o,
  output logic                   err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  idx_q;
  logic        mapped_q;
  logic        write_q;
  logic        illegal_q;
  logic [31:0] wdata_q;
  logic [31:0] reg0_q, reg1_q, reg2_q, reg4_q;
  logic [4:0]  wrPulse_q;
  logic        err_q;
  logic        lock_q;
  logic        waitReq_q;

  logic        start;
  logic        addrMapped;
  logic        commit;
  logic        accessErr;
  logic [31:0] readData;
  logic        unusedAddrBits;

  // Byte lanes are irrelevant for single-word access.
  assign unusedAddrBits = ^bus.ADDRESS[1:0];

  assign start      = bus.BEGINTRANSFER && (bus.READ || bus.WRITE);
  assign addrMapped = (bus.ADDRESS[31:5] == 27'd0) && (bus.ADDRESS[4:2] <= 3'd4);
  assign commit     = write_q && !illegal_q && mapped_q && (idx_q != 3'd3);
  assign accessErr  = illegal_q || !mapped_q || (write_q && (idx_q == 3'd3));

  always_comb begin
    readData = RD_DEFAULT;
    if (state_q == ACK && mapped_q && !illegal_q) begin
      case (idx_q)
        3'd0:    readData = reg0_q;
        3'd1:    readData = reg1_q;
        3'd2:    readData = reg2_q;
        3'd3:    readData = tx_valid_i ? tx_word_i : RD_DEFAULT;
        3'd4:    readData = reg4_q;
        default: readData = RD_DEFAULT;
      endcase
    end
  end

  assign bus.READDATA    = readData;
  assign bus.WAITREQUEST = waitReq_q;
  assign tx_taken_o      = (state_q == ACK) && !write_q && !illegal_q && mapped_q &&
                           (idx_q == 3'd3) && tx_valid_i;

  assign reg0_o     = reg0_q;
  assign reg1_o     = reg1_q;
  assign reg2_o     = reg2_q;
  assign reg4_o     = reg4_q;
  assign wr_pulse_o = wrPulse_q;
  assign lock_o     = lock_q;
  assign err_o      = err_q;

  // The request is frozen at the start edge; bus activity during WAIT/ACK is ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= 3'd0;
      mapped_q  <= 1'b0;
      write_q   <= 1'b0;
      illegal_q <= 1'b0;
      wdata_q   <= 32'd0;
      reg0_q    <= 32'd0;
      reg1_q    <= 32'd0;
      reg2_q    <= 32'd0;
      reg4_q    <= 32'd0;
      wrPulse_q <= 5'd0;
      err_q     <= 1'b0;
      lock_q    <= 1'b0;
      waitReq_q <= 1'b1;
    end else begin
      wrPulse_q <= 5'd0;
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q     <= bus.ADDRESS[4:2];
            mapped_q  <= addrMapped;
            write_q   <= bus.WRITE;
            illegal_q <= bus.READ && bus.WRITE;
            wdata_q   <= bus.WRITEDATA;
            lock_q    <= bus.LOCK;
            if (WAIT_CYCLES == 0) begin
              state_q   <= ACK;
              waitReq_q <= 1'b0;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q   <= ACK;
            waitReq_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK: begin
          state_q   <= IDLE;
          waitReq_q <= 1'b1;
          if (commit) begin
            case (idx_q)
              3'd0:    reg0_q <= wdata_q;
              3'd1:    reg1_q <= wdata_q;
              3'd2:    reg2_q <= wdata_q;
              3'd4:    reg4_q <= wdata_q;
              default: ;
            endcase
            wrPulse_q <= 5'd1 << idx_q;
          end
          if (accessErr) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          waitReq_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mm_slave_regs.sv
// Directed bench for the bridge register window: a vector table on a 2-wait-state slave
// plus hand sequences for reset, ignored starts and zero-wait back-to-back writes.
module tb_avalon_mm_slave_regs;

  localparam int unsigned WAIT_A = 2;
  localparam logic [31:0] RD_DEF = 32'hDEAD_BEEF;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  avalon_mm_slave_regs_if busA ();
  avalon_mm_slave_regs_if busB ();

  logic [31:0] reg0A, reg1A, reg2A, reg4A, txWordA;
  logic [4:0]  pulseA;
  logic        txValidA, takenA, lockA, errA;
  logic [31:0] reg0B, reg1B, reg2B, reg4B, txWordB;
  logic [4:0]  pulseB;
  logic        txValidB, takenB, lockB, errB;

  avalon_mm_slave_regs #(.WAIT_CYCLES(WAIT_A), .RD_DEFAULT(RD_DEF)) dutA (
    .CLK(CLK), .RST(RST), .bus(busA.slave),
    .reg0_o(reg0A), .reg1_o(reg1A), .reg2_o(reg2A), .reg4_o(reg4A),
    .wr_pulse_o(pulseA), .tx_word_i(txWordA), .tx_valid_i(txValidA),
    .tx_taken_o(takenA), .lock_o(lockA), .err_o(errA)
  );

  avalon_mm_slave_regs #(.WAIT_CYCLES(0), .RD_DEFAULT(RD_DEF)) dutB (
    .CLK(CLK), .RST(RST), .bus(busB.slave),
    .reg0_o(reg0B), .reg1_o(reg1B), .reg2_o(reg2B), .reg4_o(reg4B),
    .wr_pulse_o(pulseB), .tx_word_i(txWordB), .tx_valid_i(txValidB),
    .tx_taken_o(takenB), .lock_o(lockB), .err_o(errB)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lock;
    logic        txValid;
    logic [31:0] txWord;
    logic [31:0] expRdata;
    logic        expTaken;
    logic [4:0]  expPulse;
    logic        expErr;
    logic        expLock;
    logic [31:0] expReg0;
    logic [31:0] expReg1;
    logic [31:0] expReg2;
    logic [31:0] expReg4;
  } vec_t;

  vec_t vecs [13];
  vec_t v;
  int   checks = 0;
  int   errors = 0;

  // Every comparison funnels through here so the summary counts stay honest.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic idleBusA();
    busA.ADDRESS       = 32'd0;
    busA.BEGINTRANSFER = 1'b0;
    busA.READ          = 1'b0;
    busA.WRITE         = 1'b0;
    busA.WRITEDATA     = 32'd0;
    busA.LOCK          = 1'b0;
  endtask

  task automatic idleBusB();
    busB.ADDRESS       = 32'd0;
    busB.BEGINTRANSFER = 1'b0;
    busB.READ          = 1'b0;
    busB.WRITE         = 1'b0;
    busB.WRITEDATA     = 32'd0;
    busB.LOCK          = 1'b0;
  endtask

  // Runs one full transfer on slave A starting at a negedge; the bus is scrambled
  // right after the start edge so only the latched request may matter.
  task automatic applyStimulus(input vec_t tv, input string tag);
    int waits;
    busA.ADDRESS       = tv.addr;
    busA.WRITEDATA     = tv.wdata;
    busA.READ          = tv.rd;
    busA.WRITE         = tv.wr;
    busA.LOCK          = tv.lock;
    busA.BEGINTRANSFER = 1'b1;
    txValidA           = tv.txValid;
    txWordA            = tv.txWord;
    @(posedge CLK);
    @(negedge CLK);
    busA.BEGINTRANSFER = 1'b0;
    busA.READ          = 1'b0;
    busA.WRITE         = 1'b0;
    busA.LOCK          = 1'b0;
    busA.ADDRESS       = 32'hFFFF_FFFF;
    busA.WRITEDATA     = 32'h5555_5555;
    waits = 0;
    while (busA.WAITREQUEST === 1'b1 && waits < 20) begin
      @(negedge CLK);
      waits++;
    end
    checkOutput({tag, " latency"}, 32'(waits), 32'(WAIT_A));
    if (tv.rd) checkOutput({tag, " readdata"}, busA.READDATA, tv.expRdata);
    checkOutput({tag, " tx_taken"}, 32'(takenA), 32'(tv.expTaken));
    @(negedge CLK);
    checkOutput({tag, " wr_pulse"}, 32'(pulseA), 32'(tv.expPulse));
    checkOutput({tag, " err"}, 32'(errA), 32'(tv.expErr));
    checkOutput({tag, " lock"}, 32'(lockA), 32'(tv.expLock));
    checkOutput({tag, " waitreq after"}, 32'(busA.WAITREQUEST), 32'd1);
    checkOutput({tag, " taken after"}, 32'(takenA), 32'd0);
    checkOutput({tag, " reg0"}, reg0A, tv.expReg0);
    checkOutput({tag, " reg1"}, reg1A, tv.expReg1);
    checkOutput({tag, " reg2"}, reg2A, tv.expReg2);
    checkOutput({tag, " reg4"}, reg4A, tv.expReg4);
    @(negedge CLK);
    checkOutput({tag, " pulse width"}, 32'(pulseA), 32'd0);
    txValidA = 1'b0;
  endtask

  logic [31:0] bAddr  [3];
  logic [31:0] bData  [3];
  logic [4:0]  bPulse [3];

  initial begin
    //             rd    wr    addr   wdata         lck   txV   txWord        expRdata      tk    pulse     err   lk    reg0          reg1          reg2          reg4
    vecs[0]  = '{1'b0, 1'b1, 32'h08, 32'h1234_5678, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 5'b00100, 1'b0, 1'b0, 32'h0,        32'h0,        32'h1234_5678, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h08, 32'h0,         1'b1, 1'b0, 32'h0,        32'h1234_5678, 1'b0, 5'b00000, 1'b0, 1'b1, 32'h0,        32'h0,        32'h1234_5678, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0C, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 5'b00000, 1'b0, 1'b0, 32'h0,        32'h0,        32'h1234_5678, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0C, 32'h0,         1'b0, 1'b0, 32'hCAFE_F00D, RD_DEF,        1'b0, 5'b00000, 1'b0, 1'b0, 32'h0,        32'h0,        32'h1234_5678, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h00, 32'h1111_1111, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 5'b00001, 1'b0, 1'b0, 32'h1111_1111, 32'h0,       32'h1234_5678, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h10, 32'h4444_4444, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 5'b10000, 1'b0, 1'b0, 32'h1111_1111, 32'h0,       32'h1234_5678, 32'h4444_4444};
    vecs[6]  = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 1'b0, 32'h0,        32'h4444_4444, 1'b0, 5'b00000, 1'b0, 1'b0, 32'h1111_1111, 32'h0,       32'h1234_5678, 32'h4444_4444};
    vecs[7]  = '{1'b1, 1'b0, 32'h03, 32'h0,         1'b0, 1'b0, 32'h0,        32'h1111_1111, 1'b0, 5'b00000, 1'b0, 1'b0, 32'h1111_1111, 32'h0,       32'h1234_5678, 32'h4444_4444};
    vecs[8]  = '{1'b0, 1'b1, 32'h0C, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h0,        1'b0, 5'b00000, 1'b1, 1'b0, 32'h1111_1111, 32'h0,       32'h1234_5678, 32'h4444_4444};
    vecs[9]  = '{1'b1, 1'b0, 32'h14, 32'h0,         1'b0, 1'b0, 32'h0,        RD_DEF,        1'b0, 5'b00000, 1'b1, 1'b0, 32'h1111_1111, 32'h0,       32'h1234_5678, 32'h4444_4444};
    vecs[10] = '{1'b1, 1'b0, 32'h20, 32'h0,         1'b0, 1'b0, 32'h0,        RD_DEF,        1'b0, 5'b00000, 1'b1, 1'b0, 32'h1111_1111, 32'h0,       32'h1234_5678, 32'h4444_4444};
    vecs[11] = '{1'b1, 1'b1, 32'h04, 32'h9999_9999, 1'b0, 1'b0, 32'h0,        RD_DEF,        1'b0, 5'b00000, 1'b1, 1'b0, 32'h1111_1111, 32'h0,       32'h1234_5678, 32'h4444_4444};
    vecs[12] = '{1'b0, 1'b1, 32'h04, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 5'b00010, 1'b1, 1'b0, 32'h1111_1111, 32'h0BAD_F00D, 32'h1234_5678, 32'h4444_4444};

    bAddr[0] = 32'h00; bData[0] = 32'hA0A0_A0A0; bPulse[0] = 5'b00001;
    bAddr[1] = 32'h10; bData[1] = 32'hA4A4_A4A4; bPulse[1] = 5'b10000;
    bAddr[2] = 32'h04; bData[2] = 32'hA1A1_A1A1; bPulse[2] = 5'b00010;

    idleBusA();
    idleBusB();
    txWordA = 32'd0; txValidA = 1'b0;
    txWordB = 32'd0; txValidB = 1'b0;

    // Reset values while RST is held.
    repeat (2) @(negedge CLK);
    checkOutput("rst waitreqA", 32'(busA.WAITREQUEST), 32'd1);
    checkOutput("rst readdataA", busA.READDATA, RD_DEF);
    checkOutput("rst reg0A", reg0A, 32'd0);
    checkOutput("rst reg2A", reg2A, 32'd0);
    checkOutput("rst pulseA", 32'(pulseA), 32'd0);
    checkOutput("rst takenA", 32'(takenA), 32'd0);
    checkOutput("rst lockA", 32'(lockA), 32'd0);
    checkOutput("rst errA", 32'(errA), 32'd0);
    checkOutput("rst waitreqB", 32'(busB.WAITREQUEST), 32'd1);
    RST = 1'b0;

    // READ without BEGINTRANSFER must never start a transfer.
    busA.READ    = 1'b1;
    busA.ADDRESS = 32'h08;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checkOutput("no-start waitreq", 32'(busA.WAITREQUEST), 32'd1);
    end
    idleBusA();
    @(negedge CLK);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // BEGINTRANSFER raised during WAIT is neither honoured nor queued.
    busA.ADDRESS = 32'h08; busA.READ = 1'b1; busA.BEGINTRANSFER = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    busA.READ = 1'b0; busA.WRITE = 1'b1; busA.ADDRESS = 32'h00; busA.WRITEDATA = 32'h0BAD_0BAD;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("midwait ack", 32'(busA.WAITREQUEST), 32'd0);
    checkOutput("midwait readdata", busA.READDATA, 32'h1234_5678);
    idleBusA();
    @(negedge CLK);
    checkOutput("midwait pulse", 32'(pulseA), 32'd0);
    checkOutput("midwait reg0", reg0A, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("midwait not queued", 32'(busA.WAITREQUEST), 32'd1);
    end

    // Reset in the middle of a write's WAIT phase drops the write entirely.
    busA.ADDRESS = 32'h04; busA.WRITE = 1'b1; busA.WRITEDATA = 32'hA5A5_A5A5; busA.BEGINTRANSFER = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    idleBusA();
    RST = 1'b1;
    #1;
    checkOutput("rstwait waitreq", 32'(busA.WAITREQUEST), 32'd1);
    checkOutput("rstwait reg1", reg1A, 32'd0);
    checkOutput("rstwait reg2", reg2A, 32'd0);
    checkOutput("rstwait err", 32'(errA), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput("rstwait no pulse", 32'(pulseA), 32'd0);
      checkOutput("rstwait idle", 32'(busA.WAITREQUEST), 32'd1);
    end
    checkOutput("rstwait reg1 after", reg1A, 32'd0);

    // Each error source on its own, starting from a clean err_o.
    v = '{1'b1, 1'b1, 32'h08, 32'h7777_7777, 1'b0, 1'b0, 32'h0, RD_DEF, 1'b0, 5'b00000, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    applyStimulus(v, "illegal");
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("err cleared", 32'(errA), 32'd0);
    v = '{1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, RD_DEF, 1'b0, 5'b00000, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    applyStimulus(v, "unmapped");

    // Zero-wait slave: starts every 2 cycles, each in the IDLE cycle right after ACK.
    busB.ADDRESS = bAddr[0]; busB.WRITEDATA = bData[0]; busB.WRITE = 1'b1; busB.BEGINTRANSFER = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput($sformatf("b2b ack%0d", i), 32'(busB.WAITREQUEST), 32'd0);
      idleBusB();
      @(negedge CLK);
      checkOutput($sformatf("b2b pulse%0d", i), 32'(pulseB), 32'(bPulse[i]));
      checkOutput($sformatf("b2b idle%0d", i), 32'(busB.WAITREQUEST), 32'd1);
      if (i < 2) begin
        busB.ADDRESS = bAddr[i+1]; busB.WRITEDATA = bData[i+1];
        busB.WRITE = 1'b1; busB.BEGINTRANSFER = 1'b1;
      end
    end
    checkOutput("b2b reg0", reg0B, 32'hA0A0_A0A0);
    checkOutput("b2b reg1", reg1B, 32'hA1A1_A1A1);
    checkOutput("b2b reg2", reg2B, 32'h0);
    checkOutput("b2b reg4", reg4B, 32'hA4A4_A4A4);
    checkOutput("b2b err", 32'(errB), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
